mem_bus_bridge: RTL

//  Sits directly downstream of the multicycle CPU core, on its memory port.

---
 rtl/mem_bus_bridge.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_bus_bridge.sv
// CPU memory-port bridge: strobe bus to registered req/gnt/ack memory transaction.
// Single outstanding access, with completion pulse, sticky error and access counters.
module mem_bus_bridge #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 mem_ready,
    output logic                 bus_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] rd_count,
    output logic [WORD_SIZE-1:0] wr_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        RELEASE
    } state_t;

    localparam logic [15:0]          TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [WORD_SIZE-1:0] ONE      = WORD_SIZE'(1);

    state_t               state;
    state_t               state_nx;
    logic [15:0]          wcnt;
    logic [WORD_SIZE-1:0] rd_latch;
    logic                 start;
    logic                 both;
    logic                 ack_hit;
    logic                 tmo;
    logic                 drive_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        both     = 1'b0;
        ack_hit  = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            IDLE: begin
                if (readM && writeM) begin
                    both = 1'b1;
                end else if (readM || writeM) begin
                    start    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) state_nx = WAIT;
            end
            // an ack on the final counted cycle still wins over the timeout
            WAIT: begin
                if (mem_ack) begin
                    ack_hit  = 1'b1;
                    state_nx = DONE;
                end else if (wcnt == TMO_LAST) begin
                    tmo      = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: state_nx = RELEASE;
            RELEASE: begin
                if (!readM && !writeM) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            bus_err   <= 1'b0;
            wcnt      <= '0;
            rd_latch  <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (start) begin
                mem_addr <= address;
                mem_we   <= writeM;
                if (writeM) mem_wdata <= data;
            end
            if (both) bus_err <= 1'b1;
            wcnt <= (state == WAIT) ? wcnt + 16'd1 : '0;
            if (ack_hit && !mem_we) rd_latch <= mem_rdata;
            if (tmo) begin
                bus_err  <= 1'b1;
                rd_latch <= '1;
            end
            if (state == DONE) begin
                if (mem_we) wr_count <= wr_count + ONE;
                else        rd_count <= rd_count + ONE;
            end
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_ready = (state == DONE);

    assign drive_rd = !mem_we && readM
                      && ((state == DONE) || (state == RELEASE));
    assign data     = drive_rd ? rd_latch : 'z;

endmodule
